big_alu_ctrl: RTL

Sequencing controller for the floating-point mantissa BigALU. It accepts an add or multiply request through a start/done handshake and latches the operands. It then drives the BigALU mux, load and mode controls cycle by cycle: single-cycle add, or iterative repeated-addition multiply terminated by the ALU's endMultiplication flag. It captures the final result and flags runaway multiplies. It sits between the FP unit's mantissa stage and the BigALU instance.

---
 rtl/big_alu_ctrl_if.sv | 40 ++++
 rtl/big_alu_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/big_alu_ctrl_if.sv
// Request/response and BigALU control bundle between the mantissa stage and big_alu_ctrl.
// The slave modport is the controller view; master is the requester/BigALU view.
interface big_alu_ctrl_if #(
   parameter int W = 23
);
   logic         start;
   logic         op_mul;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         busy;
   logic         done;
   logic         error;
   logic [W-1:0] result_out;

   logic [W-1:0] alu_valor1;
   logic [W-1:0] alu_valor2;
   logic [3:0]   alu_ALUOp;
   logic         alu_muxA;
   logic         alu_muxB;
   logic         alu_muxC;
   logic         alu_sumOrMultiplication;
   logic         alu_loadRegA;
   logic         alu_loadRegB;
   logic [W-1:0] alu_result;
   logic         alu_endMultiplication;

   modport slave (
      input  start, op_mul, a_in, b_in, alu_result, alu_endMultiplication,
      output busy, done, error, result_out,
             alu_valor1, alu_valor2, alu_ALUOp, alu_muxA, alu_muxB, alu_muxC,
             alu_sumOrMultiplication, alu_loadRegA, alu_loadRegB
   );

   modport master (
      output start, op_mul, a_in, b_in, alu_result, alu_endMultiplication,
      input  busy, done, error, result_out,
             alu_valor1, alu_valor2, alu_ALUOp, alu_muxA, alu_muxB, alu_muxC,
             alu_sumOrMultiplication, alu_loadRegA, alu_loadRegB
   );
endinterface

// File: rtl/big_alu_ctrl.sv
// Sequences the BigALU for add (3 cycles start->done) or repeated-addition multiply (3+N cycles).
// No backpressure: start is only taken in IDLE outside the done cycle, otherwise dropped.
module big_alu_ctrl #(
   parameter int W     = 23,
   parameter int GUARD = 2
) (
   input  logic          clk,
   input  logic          reset,
   big_alu_ctrl_if.slave bus
);
   localparam int CW = W + 2;

   typedef enum logic [2:0] {
      IDLE,
      ADD,
      MUL_FIRST,
      MUL_ACC,
      CAPTURE,
      ZERO,
      ERR
   } state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  result_q, result_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;
   logic [CW-1:0] cnt_limit;
   logic          done_q, done_d;
   logic          error_q, error_d;

   logic          mux_a, mux_b, mux_c;
   logic          sum_mode;
   logic          load_a, load_b;

   // Two spare bits keep B+GUARD from wrapping when B is all ones.
   assign cnt_inc   = cnt_q + CW'(1);
   assign cnt_limit = {2'b00, b_q} + CW'(GUARD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      error_d  = 1'b0;
      mux_a    = 1'b0;
      mux_b    = 1'b0;
      mux_c    = 1'b0;
      sum_mode = 1'b0;
      load_a   = 1'b0;
      load_b   = 1'b0;

      unique case (state_q)
         IDLE: begin
            // The done pulse appears in IDLE, so it masks start for that one cycle.
            if (bus.start && !done_q) begin
               a_d   = bus.a_in;
               b_d   = bus.b_in;
               cnt_d = '0;
               if (!bus.op_mul) begin
                  state_d = ADD;
               end else if ((bus.a_in == '0) || (bus.b_in == '0)) begin
                  state_d = ZERO;
               end else begin
                  state_d = MUL_FIRST;
               end
            end
         end
         ADD: begin
            mux_a    = 1'b1;
            mux_c    = 1'b1;
            sum_mode = 1'b1;
            load_a   = 1'b1;
            load_b   = 1'b1;
            state_d  = CAPTURE;
         end
         MUL_FIRST: begin
            load_a  = 1'b1;
            load_b  = 1'b1;
            cnt_d   = CW'(1);
            state_d = MUL_ACC;
         end
         MUL_ACC: begin
            mux_b  = 1'b1;
            mux_c  = 1'b1;
            load_b = 1'b1;
            // Suppress the accumulate on the exit edge so the product is not overshot.
            load_a = ~bus.alu_endMultiplication;
            if (bus.alu_endMultiplication) begin
               state_d = CAPTURE;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc >= cnt_limit) begin
                  state_d = ERR;
               end
            end
         end
         CAPTURE: begin
            result_d = bus.alu_result;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         ZERO: begin
            result_d = '0;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         ERR: begin
            result_d = bus.alu_result;
            done_d   = 1'b1;
            error_d  = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The registered done cycle still counts as busy.
   assign bus.busy                    = (state_q != IDLE) | done_q;
   assign bus.done                    = done_q;
   assign bus.error                   = error_q;
   assign bus.result_out              = result_q;
   assign bus.alu_valor1              = a_q;
   assign bus.alu_valor2              = b_q;
   assign bus.alu_ALUOp               = 4'b0000;
   assign bus.alu_muxA                = mux_a;
   assign bus.alu_muxB                = mux_b;
   assign bus.alu_muxC                = mux_c;
   assign bus.alu_sumOrMultiplication = sum_mode;
   assign bus.alu_loadRegA            = load_a;
   assign bus.alu_loadRegB            = load_b;
endmodule
